// File: rtl/core_arbiter.sv
// core_arbiter: round-robin share of one div/root core among NREQ requesters.
// Ports: req_* requester side, core_* core side, rsp_* tagged result, busy/err_spurious status.
module core_arbiter #(
  parameter  int NREQ    = 4,
  parameter  int TIMEOUT = 255,
  localparam int IW      = $clog2(NREQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ-1:0]    req_mode,
  input  logic [NREQ*10-1:0] req_data_1,
  input  logic [NREQ*3-1:0]  req_data_2,
  output logic [NREQ-1:0]    req_ready,
  output logic               core_in_valid,
  output logic               core_in_mode,
  output logic [9:0]         core_in_data_1,
  output logic [2:0]         core_in_data_2,
  input  logic               core_out_valid,
  input  logic [19:0]        core_out_data,
  output logic               rsp_valid,
  output logic [IW-1:0]      rsp_id,
  output logic [19:0]        rsp_data,
  output logic               rsp_timeout,
  output logic               busy,
  output logic               err_spurious
);

  typedef enum logic [1:0] {
    S_IDLE, S_ISSUE, S_WAIT, S_RESP
  } state_t;

  state_t        state;
  state_t        nxt;
  logic [IW-1:0] ptr;
  logic [IW-1:0] id_q;
  logic [9:0]    wcnt;

  logic [IW-1:0] win;
  logic          win_ok;
  logic [IW:0]   s;
  logic          wcnt_end;
  logic          go_issue;
  logic          go_resp;

  logic [NREQ-1:0] ready_d;
  logic            mode_d;
  logic [9:0]      d1_d;
  logic [2:0]      d2_d;
  logic [IW-1:0]   id_d;
  logic [19:0]     data_d;
  logic            to_d;
  logic            spur_d;

  // First pending bit at or above ptr, wrapping at NREQ.
  always_comb begin
    win    = '0;
    win_ok = 1'b0;
    s      = '0;
    for (int k = 0; k < NREQ; k++) begin
      s = {1'b0, ptr} + (IW+1)'(k);
      if (s >= (IW+1)'(NREQ))
        s = s - (IW+1)'(NREQ);
      if (!win_ok && req_valid[s[IW-1:0]]) begin
        win_ok = 1'b1;
        win    = s[IW-1:0];
      end
    end
  end

  assign wcnt_end = (wcnt == 10'(TIMEOUT-1));

  always_comb begin
    nxt = state;
    unique case (state)
      S_IDLE:  if (win_ok) nxt = S_ISSUE;
      S_ISSUE: nxt = S_WAIT;
      S_WAIT:  if (core_out_valid || wcnt_end)
                 nxt = S_RESP;
      S_RESP:  nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
  end

  assign go_issue = (state == S_IDLE) && win_ok;
  assign go_resp  = (state == S_WAIT) &&
                    (nxt == S_RESP);

  // Next values of the registered outputs.
  always_comb begin
    ready_d = '0;
    mode_d  = 1'b0;
    d1_d    = '0;
    d2_d    = '0;
    id_d    = '0;
    data_d  = '0;
    to_d    = 1'b0;
    unique case (1'b1)
      go_issue: begin
        ready_d[win] = 1'b1;
        mode_d = req_mode[win];
        d1_d   = req_data_1[int'(win)*10 +: 10];
        d2_d   = req_data_2[int'(win)*3 +: 3];
      end
      go_resp: begin
        id_d = id_q;
        // A result on the timeout cycle wins.
        if (core_out_valid)
          data_d = core_out_data;
        else
          to_d = 1'b1;
      end
      default: ;
    endcase
    spur_d = err_spurious |
             (core_out_valid && state != S_WAIT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      ptr            <= '0;
      id_q           <= '0;
      wcnt           <= '0;
      req_ready      <= '0;
      core_in_valid  <= 1'b0;
      core_in_mode   <= 1'b0;
      core_in_data_1 <= '0;
      core_in_data_2 <= '0;
      rsp_valid      <= 1'b0;
      rsp_id         <= '0;
      rsp_data       <= '0;
      rsp_timeout    <= 1'b0;
      busy           <= 1'b0;
      err_spurious   <= 1'b0;
    end else begin
      state <= nxt;
      if (go_issue)
        id_q <= win;
      if (state == S_ISSUE) begin
        if (id_q == IW'(NREQ-1))
          ptr <= '0;
        else
          ptr <= id_q + 1'b1;
      end
      wcnt <= (state == S_WAIT) ?
              wcnt + 10'd1 : 10'd0;
      req_ready      <= ready_d;
      core_in_valid  <= go_issue;
      core_in_mode   <= mode_d;
      core_in_data_1 <= d1_d;
      core_in_data_2 <= d2_d;
      rsp_valid      <= go_resp;
      rsp_id         <= id_d;
      rsp_data       <= data_d;
      rsp_timeout    <= to_d;
      busy           <= (nxt != S_IDLE);
      err_spurious   <= spur_d;
    end
  end

endmodule

// File: tb/tb_core_arbiter.sv
// tb_core_arbiter: directed bench for core_arbiter.
// Core responses are driven by hand from the stimulus sequence.
module tb_core_arbiter;

  localparam int NREQ = 4;
  localparam int IW   = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_mode;
  logic [NREQ*10-1:0] req_data_1;
  logic [NREQ*3-1:0] req_data_2;
  logic [NREQ-1:0]   req_ready;
  logic              core_in_valid;
  logic              core_in_mode;
  logic [9:0]        core_in_data_1;
  logic [2:0]        core_in_data_2;
  logic              core_out_valid;
  logic [19:0]       core_out_data;
  logic              rsp_valid;
  logic [IW-1:0]     rsp_id;
  logic [19:0]       rsp_data;
  logic              rsp_timeout;
  logic              busy;
  logic              err_spurious;

  int checks   = 0;
  int failures = 0;
  int civ_cnt  = 0;
  int rsp_cnt  = 0;
  int rdy3_cnt = 0;
  int id3_cnt  = 0;

  core_arbiter #(.NREQ(NREQ), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_mode(req_mode),
    .req_data_1(req_data_1), .req_data_2(req_data_2),
    .req_ready(req_ready),
    .core_in_valid(core_in_valid),
    .core_in_mode(core_in_mode),
    .core_in_data_1(core_in_data_1),
    .core_in_data_2(core_in_data_2),
    .core_out_valid(core_out_valid),
    .core_out_data(core_out_data),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_timeout(rsp_timeout),
    .busy(busy), .err_spurious(err_spurious)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (core_in_valid) civ_cnt++;
    if (rsp_valid) rsp_cnt++;
    if (req_ready[3]) rdy3_cnt++;
    if (rsp_valid && rsp_id == 2'd3) id3_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic wait_issue(input string tag);
    for (int n = 0; n < 32 && !core_in_valid; n++)
      tick();
    chk(tag, 32'(core_in_valid), 32'd1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = '0;
    core_out_valid = 1'b0;
    core_out_data = '0;
    tick();
    rst = 1'b0;
  endtask

  int e;
  int base;

  initial begin
    rst = 1'b1;
    req_valid = '0;
    req_mode = '0;
    req_data_1 = '0;
    req_data_2 = '0;
    core_out_valid = 1'b0;
    core_out_data = '0;
    repeat (2) tick();
    rst = 1'b0;

    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_civ", 32'(core_in_valid), 32'd0);
    chk("rst_d1", 32'(core_in_data_1), 32'd0);
    chk("rst_rsp", 32'(rsp_valid), 32'd0);
    chk("rst_rdata", 32'(rsp_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err", 32'(err_spurious), 32'd0);

    // single request from requester 2
    req_valid = 4'b0100;
    req_mode = 4'b0100;
    req_data_1[20 +: 10] = 10'd625;
    req_data_2[6 +: 3] = 3'd2;
    tick();
    chk("s_ready", 32'(req_ready), 32'b0100);
    chk("s_civ", 32'(core_in_valid), 32'd1);
    chk("s_mode", 32'(core_in_mode), 32'd1);
    chk("s_d1", 32'(core_in_data_1), 32'd625);
    chk("s_d2", 32'(core_in_data_2), 32'd2);
    chk("s_busy", 32'(busy), 32'd1);
    req_valid = '0;
    tick();
    chk("s_civ_off", 32'(core_in_valid), 32'd0);
    chk("s_d1_off", 32'(core_in_data_1), 32'd0);
    repeat (4) tick();
    core_out_valid = 1'b1;
    core_out_data = 20'h19000;
    tick();
    core_out_valid = 1'b0;
    core_out_data = '0;
    chk("s_rsp", 32'(rsp_valid), 32'd1);
    chk("s_id", 32'(rsp_id), 32'd2);
    chk("s_data", 32'(rsp_data), 32'h19000);
    chk("s_to", 32'(rsp_timeout), 32'd0);
    tick();
    chk("s_rsp_off", 32'(rsp_valid), 32'd0);
    chk("s_data_off", 32'(rsp_data), 32'd0);
    chk("s_idle", 32'(busy), 32'd0);

    // round robin, all pending, 3-cycle core
    do_reset();
    base = civ_cnt;
    req_valid = 4'hF;
    req_mode = 4'b1010;
    req_data_1 = {10'd400, 10'd300, 10'd200, 10'd100};
    req_data_2 = {3'd4, 3'd3, 3'd2, 3'd1};
    for (int op = 0; op < 8; op++) begin
      e = op % 4;
      wait_issue("rr_issue");
      chk("rr_ready", 32'(req_ready), 32'd1 << e);
      chk("rr_d1", 32'(core_in_data_1), 32'(100*(e+1)));
      repeat (3) tick();
      core_out_valid = 1'b1;
      core_out_data = 20'h100 + 20'(op);
      tick();
      core_out_valid = 1'b0;
      chk("rr_rsp", 32'(rsp_valid), 32'd1);
      chk("rr_id", 32'(rsp_id), 32'(e));
      chk("rr_data", 32'(rsp_data), 32'h100 + 32'(op));
    end
    req_valid = '0;
    repeat (4) tick();
    chk("rr_civ_cnt", 32'(civ_cnt - base), 32'd8);

    // timeout with TIMEOUT=8
    do_reset();
    req_valid = 4'b0001;
    wait_issue("to_issue");
    req_valid = '0;
    repeat (8) tick();
    chk("to_early", 32'(rsp_valid), 32'd0);
    tick();
    chk("to_rsp", 32'(rsp_valid), 32'd1);
    chk("to_flag", 32'(rsp_timeout), 32'd1);
    chk("to_data", 32'(rsp_data), 32'd0);
    chk("to_id", 32'(rsp_id), 32'd0);
    chk("to_err0", 32'(err_spurious), 32'd0);
    tick();
    core_out_valid = 1'b1;
    core_out_data = 20'h12345;
    tick();
    core_out_valid = 1'b0;
    chk("late_err", 32'(err_spurious), 32'd1);
    chk("late_rsp", 32'(rsp_valid), 32'd0);
    tick();
    chk("err_sticky", 32'(err_spurious), 32'd1);

    // result on the timeout cycle
    do_reset();
    chk("tie_err_clr", 32'(err_spurious), 32'd0);
    req_valid = 4'b0010;
    wait_issue("tie_issue");
    req_valid = '0;
    repeat (8) tick();
    core_out_valid = 1'b1;
    core_out_data = 20'hABCDE;
    tick();
    core_out_valid = 1'b0;
    chk("tie_rsp", 32'(rsp_valid), 32'd1);
    chk("tie_to", 32'(rsp_timeout), 32'd0);
    chk("tie_data", 32'(rsp_data), 32'hABCDE);
    chk("tie_id", 32'(rsp_id), 32'd1);
    tick();
    chk("tie_err", 32'(err_spurious), 32'd0);

    // reset during WAIT
    do_reset();
    base = rsp_cnt;
    req_valid = 4'b0010;
    wait_issue("rw_issue");
    chk("rw_ready0", 32'(req_ready), 32'b0010);
    repeat (2) tick();
    chk("rw_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    req_valid = 4'b1010;
    tick();
    rst = 1'b0;
    chk("rw_ready", 32'(req_ready), 32'd0);
    chk("rw_civ", 32'(core_in_valid), 32'd0);
    chk("rw_rsp", 32'(rsp_valid), 32'd0);
    chk("rw_busy0", 32'(busy), 32'd0);
    tick();
    chk("rw_first", 32'(req_ready), 32'b0010);
    req_valid = 4'b1000;
    repeat (2) tick();
    core_out_valid = 1'b1;
    core_out_data = 20'h00111;
    tick();
    core_out_valid = 1'b0;
    chk("rw_id1", 32'(rsp_id), 32'd1);
    chk("rw_data1", 32'(rsp_data), 32'h00111);
    wait_issue("rw_issue3");
    chk("rw_second", 32'(req_ready), 32'b1000);
    req_valid = '0;
    tick();
    core_out_valid = 1'b1;
    core_out_data = 20'h00333;
    tick();
    core_out_valid = 1'b0;
    chk("rw_id3", 32'(rsp_id), 32'd3);
    tick();
    chk("rw_rsp_cnt", 32'(rsp_cnt - base), 32'd2);

    // requester 3 withdraws before grant
    do_reset();
    base = rdy3_cnt;
    e = id3_cnt;
    req_valid = 4'b0001;
    wait_issue("wd_issue");
    req_valid = 4'b1000;
    repeat (3) tick();
    req_valid = '0;
    core_out_valid = 1'b1;
    core_out_data = 20'h00001;
    tick();
    core_out_valid = 1'b0;
    chk("wd_id0", 32'(rsp_id), 32'd0);
    repeat (10) tick();
    chk("wd_ready3", 32'(rdy3_cnt - base), 32'd0);
    chk("wd_id3", 32'(id3_cnt - e), 32'd0);
    chk("wd_busy", 32'(busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/core_arbiter.md
# core_arbiter

Shares one division/root `CORE` between `NREQ` requesters. Round-robin arbitration picks one pending request, issues it to the core as a single-cycle `in_valid` transaction, and waits for the core's `out_valid`. It then returns the 20-bit result (10-bit integer part, 10-bit fraction) tagged with the requester index. A watchdog aborts a request the core never answers, so the arbiter cannot hang.

## Interface
- `NREQ`, default 4: number of requesters, 2..8.
- `TIMEOUT`, default 255: maximum WAIT cycles before abort, 2..1023.
- `IW` (derived, not overridable): $clog2(NREQ).
- `clk`  in  1: single clock; all logic rising-edge.
- `rst`  in  1: one clock; reset is synchronous and active-high.
- `req_valid`  in  NREQ: bit i = requester i has a pending operation.
- `req_mode`  in  NREQ: per-requester mode bit, passed to core `in_mode`.
- `req_data_1`  in  NREQ*10: requester i uses bits [10i+9:10i].
- `req_data_2`  in  NREQ*3: requester i uses bits [3i+2:3i].
- `req_ready`  out  NREQ: one-hot one-cycle pulse; the request is accepted.
- `core_in_valid`  out  1: to core `in_valid`.
- `core_in_mode`  out  1: to core `in_mode`.
- `core_in_data_1`  out  10: to core `in_data_1`.
- `core_in_data_2`  out  3: to core `in_data_2`.
- `core_out_valid`  in  1: from core `out_valid`.
- `core_out_data`  in  20: from core `out_data`.
- `rsp_valid`  out  1: one-cycle pulse; response fields valid.
- `rsp_id`  out  IW: index of the requester the response belongs to.
- `rsp_data`  out  20: core result; 0 on timeout.
- `rsp_timeout`  out  1: the response is an abort.
- `busy`  out  1: state is not IDLE.
- `err_spurious`  out  1: sticky; `core_out_valid` was seen outside WAIT. Cleared only by `rst`.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP. All outputs are registered.
- IDLE:
  - If any `req_valid` bit is set, select the winner: the first set bit searching upward from `ptr`, wrapping past NREQ-1 to 0.
  - Latch the winner's id, mode, data_1 and data_2, then go to ISSUE.
- ISSUE (exactly 1 cycle):
  - `core_in_valid`=1, core data = latched values, `req_ready[id]`=1.
  - `ptr` <= id+1 mod NREQ. Go to WAIT.
- WAIT:
  - `wcnt` is cleared on entry and increments every WAIT cycle.
  - On `core_out_valid`=1: latch `core_out_data` and go to RESP, timeout=0.
  - Otherwise, when `wcnt` == TIMEOUT-1: go to RESP with timeout=1, data=0.
  - If `core_out_valid` arrives on the timeout cycle, the valid result wins.
- RESP (1 cycle): `rsp_valid`=1 with the latched id, data and timeout. Go to IDLE.
- Requester contract: hold `req_valid` and data stable until `req_ready`. Deasserting before grant withdraws the request with no response.
- Core-side outputs are 0 whenever `core_in_valid`=0. Response fields are 0 whenever `rsp_valid`=0.
- Spurious output: `core_out_valid` in IDLE, ISSUE or RESP sets `err_spurious` and is otherwise ignored. This includes a late result after a timeout.
- Reset behaviour:
  - Reset values: state IDLE, `ptr`=0, `wcnt`=0, every output 0.
  - Reset mid-operation abandons the request with no response and does not reset the core.

## Timing
- `req_valid` seen in IDLE at cycle c:
  - `req_ready` and `core_in_valid` at c+1.
  - WAIT from c+2.
- `core_out_valid` at cycle d in WAIT: `rsp_valid` at d+1, IDLE at d+2.
- Earliest next grant is sampled at d+2, with the next ISSUE at d+3.
- Throughput is at most one outstanding core operation; no pipelining.
- Timeout response comes TIMEOUT+1 cycles after ISSUE.
- Fairness: with all NREQ requesters continuously pending, grants rotate 0,1,...,NREQ-1,0,... A requester waits at most NREQ-1 other operations.

## Test plan
- Single request: req 2, mode=1, data_1=10'd625, data_2=3'd2, core model answers 20'h19000 after 5 cycles. Required: `req_ready`=4'b0100 at c+1, then `rsp_valid` with `rsp_id`=2, `rsp_data`=20'h19000, `rsp_timeout`=0.
- Round-robin: all four requesters pending continuously, 3-cycle core latency, 8 operations. Required: `rsp_id` sequence 0,1,2,3,0,1,2,3; exactly one `core_in_valid` per operation.
- Timeout: TIMEOUT=8, core never responds. Required: `rsp_valid` 9 cycles after ISSUE with `rsp_timeout`=1, `rsp_data`=0. A late `core_out_valid` afterwards sets `err_spurious`=1.
- Tie at the timeout cycle: `core_out_valid` on `wcnt`==TIMEOUT-1. Required: `rsp_timeout`=0 and real data returned.
- Reset mid-WAIT: assert `rst` for 1 cycle during WAIT. Required: all outputs 0 and `ptr`=0. With req 1 and req 3 pending afterwards, req 1 is granted first; no response is issued for the abandoned operation.
- Withdrawal: req 3 drops `req_valid` before it is granted. Required: no `req_ready[3]` and no `rsp_id`=3.
